// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl -- shares two asynchronous SRAM banks (base and ext) between
// NREQ requesters, one outstanding access at a time.
// Port 0 is instruction fetch, port NREQ-1 is data.
// Build option SRAM_ARB_RR_EN: round-robin arbitration. When it is not defined,
// the arbiter uses fixed priority and the highest-index valid port wins.
module sram_arb_ctrl #(
    parameter int NREQ        = 2,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_we,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    inout  wire  [31:0]       base_ram_data,
    output logic [19:0]       base_ram_addr,
    output logic [3:0]        base_ram_be_n,
    output logic              base_ram_ce_n,
    output logic              base_ram_oe_n,
    output logic              base_ram_we_n,
    inout  wire  [31:0]       ext_ram_data,
    output logic [19:0]       ext_ram_addr,
    output logic [3:0]        ext_ram_be_n,
    output logic              ext_ram_ce_n,
    output logic              ext_ram_oe_n,
    output logic              ext_ram_we_n
);

    localparam int         PW          = (NREQ > 2) ? 2 : 1;
    localparam logic [2:0] LAST_CNT    = 3'(WAIT_CYCLES);
    localparam logic [9:0] BASE_REGION = 10'h200;
    localparam logic [9:0] EXT_REGION  = 10'h201;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [2:0]    cnt_q;
    logic [PW-1:0] port_q;
    logic [3:0]    we_q;
    logic [31:0]   wdata_q;
    logic [19:0]   sram_addr_q;
    logic          ext_sel_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [PW-1:0] grant_idx;
    logic          grant_fire;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_we;
    logic          sel_base;
    logic          sel_ext;
    logic          sel_in_range;
    logic          base_drive;
    logic          ext_drive;
    logic          unused_addr_bits;

`ifdef SRAM_ARB_RR_EN
    logic [PW-1:0] rr_ptr_q;

    // Round-robin pick: search upward from the port after the last one granted.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + 1 + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_valid[idx]) begin
                grant_idx = PW'(idx);
            end
        end
    end

    // Remember the most recently granted port so the next search starts after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= PW'(NREQ - 1);
        end else if (grant_fire) begin
            rr_ptr_q <= grant_idx;
        end
    end
`else
    // Fixed priority pick: the highest-index valid port wins, so data beats fetch.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                grant_idx = PW'(i);
            end
        end
    end
`endif

    assign grant_fire = (state_q == IDLE) && (|req_valid) && !reset;

    // Select the winning port's payload and decode which bank it targets.
    always_comb begin
        sel_addr     = req_addr[32*grant_idx +: 32];
        sel_wdata    = req_wdata[32*grant_idx +: 32];
        sel_we       = req_we[4*grant_idx +: 4];
        sel_base     = (sel_addr[31:22] == BASE_REGION);
        sel_ext      = (sel_addr[31:22] == EXT_REGION);
        sel_in_range = sel_base || sel_ext;
    end

    assign unused_addr_bits = ^sel_addr[1:0];

    // One-hot grant pulse, only while the controller sits idle.
    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus bank strobes and bus-drive enables from the registered access.
    always_comb begin
        state_d       = state_q;
        base_ram_ce_n = 1'b1;
        base_ram_oe_n = 1'b1;
        base_ram_we_n = 1'b1;
        base_ram_be_n = 4'hF;
        ext_ram_ce_n  = 1'b1;
        ext_ram_oe_n  = 1'b1;
        ext_ram_we_n  = 1'b1;
        ext_ram_be_n  = 4'hF;
        base_drive    = 1'b0;
        ext_drive     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d = sel_in_range ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
                if (ext_sel_q) begin
                    ext_ram_ce_n = 1'b0;
                    if (we_q == 4'b0000) begin
                        ext_ram_oe_n = 1'b0;
                        ext_ram_be_n = 4'b0000;
                    end else begin
                        ext_ram_be_n = ~we_q;
                        ext_ram_we_n = (cnt_q == LAST_CNT);
                        ext_drive    = 1'b1;
                    end
                end else begin
                    base_ram_ce_n = 1'b0;
                    if (we_q == 4'b0000) begin
                        base_ram_oe_n = 1'b0;
                        base_ram_be_n = 4'b0000;
                    end else begin
                        base_ram_be_n = ~we_q;
                        base_ram_we_n = (cnt_q == LAST_CNT);
                        base_drive    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted request, pace the access, and capture read data at its end.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 3'd0;
            port_q      <= '0;
            we_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            sram_addr_q <= 20'h0;
            ext_sel_q   <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        port_q      <= grant_idx;
                        we_q        <= sel_in_range ? sel_we : 4'b0000;
                        wdata_q     <= sel_wdata;
                        sram_addr_q <= sel_in_range ? sel_addr[21:2] : 20'h0;
                        ext_sel_q   <= sel_ext;
                        err_q       <= !sel_in_range;
                        rdata_q     <= 32'h0;
                        cnt_q       <= 3'd0;
                    end
                end
                ACCESS: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= 3'd0;
                        if (we_q == 4'b0000) begin
                            rdata_q <= ext_sel_q ? ext_ram_data : base_ram_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    cnt_q <= 3'd0;
                end
            endcase
        end
    end

    // Completion pulse back to the port that owned the access.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        if ((state_q == DONE) && !reset) begin
            rsp_valid[port_q] = 1'b1;
            rsp_rdata         = rdata_q;
            rsp_err           = err_q;
        end
    end

    assign base_ram_addr = sram_addr_q;
    assign ext_ram_addr  = sram_addr_q;
    assign base_ram_data = base_drive ? wdata_q : 32'hzzzz_zzzz;
    assign ext_ram_data  = ext_drive  ? wdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl -- directed bench for sram_arb_ctrl with a small SRAM model
// on each bank and a queue of expected completions.
module tb_sram_arb_ctrl;

    localparam int NREQ        = 2;
    localparam int WAIT_CYCLES = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_we;
    logic [32*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    wire  [31:0]       base_ram_data;
    logic [19:0]       base_ram_addr;
    logic [3:0]        base_ram_be_n;
    logic              base_ram_ce_n;
    logic              base_ram_oe_n;
    logic              base_ram_we_n;
    wire  [31:0]       ext_ram_data;
    logic [19:0]       ext_ram_addr;
    logic [3:0]        ext_ram_be_n;
    logic              ext_ram_ce_n;
    logic              ext_ram_oe_n;
    logic              ext_ram_we_n;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;
    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];
    int          base_ce_lo, base_oe_lo, base_we_lo;
    int          ext_ce_lo, ext_oe_lo, ext_we_lo;
    logic [19:0] last_base_addr, last_ext_addr;
    logic [3:0]  last_ext_be_n;

    sram_arb_ctrl #(.NREQ(NREQ), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .base_ram_data (base_ram_data),
        .base_ram_addr (base_ram_addr),
        .base_ram_be_n (base_ram_be_n),
        .base_ram_ce_n (base_ram_ce_n),
        .base_ram_oe_n (base_ram_oe_n),
        .base_ram_we_n (base_ram_we_n),
        .ext_ram_data  (ext_ram_data),
        .ext_ram_addr  (ext_ram_addr),
        .ext_ram_be_n  (ext_ram_be_n),
        .ext_ram_ce_n  (ext_ram_ce_n),
        .ext_ram_oe_n  (ext_ram_oe_n),
        .ext_ram_we_n  (ext_ram_we_n)
    );

    // Free-running clock and a cycle counter used to time completions.
    always #10 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // SRAM models: drive read data while selected with oe low.
    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] : 32'hzzzz_zzzz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[7:0]] : 32'hzzzz_zzzz;

    // Preload known words on reset; otherwise commit enabled bytes while we_n is low.
    always @(posedge clk) begin
        if (reset) begin
            base_mem[4]   <= 32'h1234_5678;
            ext_mem[2]    <= 32'h1111_2222;
            ext_mem[255]  <= 32'h5A5A_A5A5;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
                    base_mem[base_ram_addr[7:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
                if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
                    ext_mem[ext_ram_addr[7:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
            end
        end
    end

    // Hard stop in case something unforeseen blocks the sequence.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        base_ce_lo = 0; base_oe_lo = 0; base_we_lo = 0;
        ext_ce_lo  = 0; ext_oe_lo  = 0; ext_we_lo  = 0;
        last_base_addr = 20'h0; last_ext_addr = 20'h0; last_ext_be_n = 4'hF;
    endtask

    task automatic sampleBus();
        if (!base_ram_ce_n) begin base_ce_lo++; last_base_addr = base_ram_addr; end
        if (!base_ram_oe_n) base_oe_lo++;
        if (!base_ram_we_n) base_we_lo++;
        if (!ext_ram_ce_n) begin ext_ce_lo++; last_ext_addr = ext_ram_addr; last_ext_be_n = ext_ram_be_n; end
        if (!ext_ram_oe_n) ext_oe_lo++;
        if (!ext_ram_we_n) ext_we_lo++;
    endtask

    // Advance one cycle, sample mid-cycle, and score any completion against the queue.
    task automatic stepCycle();
        exp_t e;
        @(negedge clk);
        #1;
        sampleBus();
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_port",  32'(rsp_valid), 32'(1) << e.port);
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err",   32'(rsp_err), 32'(e.err));
                checkOutput("rsp_cycle", 32'(cycle), 32'(e.cycle));
            end
        end
    endtask

    task automatic drainResponses(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_drain"}, 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    // Present one request on a port, wait for its grant, queue the expected completion,
    // then withdraw it and scramble the payload so late changes would be visible.
    task automatic applyStimulus(input int port, input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input bit expect_rsp, input string tag);
        int n;
        exp_t e;
        clearCounts();
        req_we[4*port +: 4]     = we;
        req_addr[32*port +: 32] = addr;
        req_wdata[32*port +: 32] = wdata;
        req_valid[port]         = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_grant"}, 32'(req_ready), 32'(1) << port);
        if (expect_rsp && req_ready != '0) begin
            e.port  = port;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cycle = cycle + (exp_err ? 1 : WAIT_CYCLES + 2);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[port]          = 1'b0;
        req_we[4*port +: 4]      = ~we;
        req_addr[32*port +: 32]  = ~addr;
        req_wdata[32*port +: 32] = ~wdata;
    endtask

    initial begin
        int n;
        logic [NREQ-1:0] exp_grant;
        exp_t e;

        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clearCounts();
        $display("[TB] start");

        // Reset state, including grant suppression while reset is high.
        repeat (3) @(negedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err",   32'(rsp_err), 32'h0);
        checkOutput("reset_base_strb", {28'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n, 1'b1}, 32'hF);
        checkOutput("reset_ext_strb",  {28'h0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, 1'b1}, 32'hF);
        checkOutput("reset_be_n",      {24'h0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
        checkOutput("reset_addr",      {12'h0, base_ram_addr}, 32'h0);
        req_valid = '0;
        reset     = 1'b0;

        // V1: fetch port reads base word 4.
        applyStimulus(0, 4'b0000, 32'h8000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b1, "v1");
        drainResponses("v1");
        checkOutput("v1_base_addr", {12'h0, last_base_addr}, 32'h4);
        checkOutput("v1_oe_cycles", 32'(base_oe_lo), 32'd2);
        checkOutput("v1_we_cycles", 32'(base_we_lo), 32'd0);
        checkOutput("v1_ext_idle",  32'(ext_ce_lo),  32'd0);

        // V2: data port writes the low half of ext word 2.
        applyStimulus(1, 4'b0011, 32'h8040_0008, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b1, "v2");
        drainResponses("v2");
        checkOutput("v2_be_n",      {28'h0, last_ext_be_n}, 32'hC);
        checkOutput("v2_we_cycles", 32'(ext_we_lo), 32'd1);
        checkOutput("v2_ext_addr",  {12'h0, last_ext_addr}, 32'h2);
        checkOutput("v2_ext_word",  ext_mem[2], 32'h1111_CCDD);
        checkOutput("v2_base_idle", 32'(base_ce_lo), 32'd0);

        // Top word of the ext region is still in range.
        applyStimulus(0, 4'b0000, 32'h807F_FFFC, 32'h0, 32'h5A5A_A5A5, 1'b0, 1'b1, "top");
        drainResponses("top");
        checkOutput("top_ext_addr", {12'h0, last_ext_addr}, 32'hF_FFFF);

        // V4 and region edges: out-of-range accesses never touch a bank.
        applyStimulus(0, 4'b0000, 32'h9000_0000, 32'h0, 32'h0, 1'b1, 1'b1, "v4");
        drainResponses("v4");
        checkOutput("v4_no_ce", 32'(base_ce_lo + ext_ce_lo), 32'd0);
        applyStimulus(1, 4'b1111, 32'h8080_0000, 32'h0123_4567, 32'h0, 1'b1, 1'b1, "above");
        drainResponses("above");
        checkOutput("above_no_ce", 32'(base_ce_lo + ext_ce_lo), 32'd0);
        applyStimulus(0, 4'b0000, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b1, "below");
        drainResponses("below");
        checkOutput("below_no_ce", 32'(base_ce_lo + ext_ce_lo), 32'd0);

        // V5: reset during the first access cycle of a write abandons it.
        applyStimulus(0, 4'b1111, 32'h8000_0020, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, "v5");
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("v5_we_active", 32'(base_ram_we_n), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("v5_strobes_high", {28'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n, 1'b1}, 32'hF);
        checkOutput("v5_be_n_high",    {28'h0, base_ram_be_n}, 32'hF);
        checkOutput("v5_addr_zero",    {12'h0, base_ram_addr}, 32'h0);
        checkOutput("v5_no_rsp",       32'(rsp_valid), 32'h0);
        reset = 1'b0;
        repeat (5) stepCycle();
        applyStimulus(0, 4'b0000, 32'h8000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b1, "v5_after");
        drainResponses("v5_after");

        // V3: both ports request back to back after a fresh reset.
        reset = 1'b1;
        repeat (2) stepCycle();
        reset = 1'b0;
        req_we    = '0;
        req_addr  = {32'h8040_0008, 32'h8000_0010};
        req_wdata = '0;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == '0 && n < 40) begin
                stepCycle();
                n++;
            end
`ifdef SRAM_ARB_RR_EN
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b10;
`endif
            checkOutput($sformatf("v3_grant%0d", k), 32'(req_ready), 32'(exp_grant));
            if (req_ready != '0) begin
                e.port  = req_ready[1] ? 1 : 0;
                e.rdata = req_ready[1] ? 32'h1111_2222 : 32'h1234_5678;
                e.err   = 1'b0;
                e.cycle = cycle + WAIT_CYCLES + 2;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drainResponses("v3");

        // Quiet bus afterwards: any stray completion is flagged by stepCycle.
        repeat (4) stepCycle();
        checkOutput("final_idle_ce", {30'h0, base_ram_ce_n, ext_ram_ce_n}, 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
- REQ-001 Parameter NREQ, default 2: number of requester ports, legal 2..4; port 0 = instruction fetch, port NREQ-1 = data.
- REQ-002 Parameter WAIT_CYCLES, default 1: SRAM strobe hold cycles, legal 1..7.
- REQ-003 Ports:
  - clk  in  1  system clock.
  - reset  in  1  synchronous, active-high reset, sampled on posedge clk.
  - req_valid  in  NREQ  request pending, one bit per port.
  - req_we  in  4*NREQ  byte write strobes per port; 0000 = read.
  - req_addr  in  32*NREQ  byte address per port.
  - req_wdata  in  32*NREQ  write data per port.
  - req_ready  out  NREQ  one-hot grant pulse; request accepted this cycle.
  - rsp_valid  out  NREQ  one-hot completion pulse.
  - rsp_rdata  out  32  read data, shared by all ports.
  - rsp_err  out  1  completion was out of range, qualified by rsp_valid.
  - base_ram_data / ext_ram_data  inout  32  SRAM data buses.
  - base_ram_addr / ext_ram_addr  out  20  SRAM word addresses.
  - base_ram_be_n / ext_ram_be_n  out  4  byte enables, active low.
  - base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n  out  1 each  strobes, active low.

Function
- REQ-004 Address decode: 0x8000_0000..0x803F_FFFF = base RAM; 0x8040_0000..0x807F_FFFF = ext RAM; SRAM address = addr[21:2]; all other addresses are out of range.
- REQ-005 FSM states: IDLE, ACCESS, DONE; single outstanding access.
- REQ-006 IDLE with any req_valid set: arbitrate, pulse req_ready[i] combinationally in that cycle, latch addr/we/wdata/port, then go to ACCESS; with no req_valid set, stay in IDLE.
- REQ-007 In-range access: ACCESS lasts WAIT_CYCLES+1 cycles, counted by a 3-bit counter.
  - Selected bank: ce_n=0 throughout.
  - Reads: oe_n=0, be_n=0000.
  - Writes: be_n=~we; we_n=0 for the first WAIT_CYCLES cycles and 1 in the final cycle as data hold; data bus driven with wdata throughout.
- REQ-008 The unselected bank keeps all strobes high; a data bus is high-Z whenever no write is being driven on it.
- REQ-009 Read data is registered at the end of the final ACCESS cycle.
- REQ-010 DONE lasts 1 cycle: rsp_valid[port]=1; rsp_rdata = read data, or 0 for writes; then IDLE.
  - Read latency: req_ready at cycle T gives rsp_valid at T+WAIT_CYCLES+2.
  - Peak rate: one access per WAIT_CYCLES+3 cycles.
- REQ-011 Out-of-range access: no strobe asserted; ACCESS is skipped; DONE follows the grant cycle with rsp_err=1 and rsp_rdata=0.
- REQ-012 Requesters hold req_valid and payload until req_ready; deasserting before the grant is permitted and drops the request.
- REQ-013 Payload changes after req_ready have no effect on the access in flight.

Reset
- REQ-014 When reset=1: FSM=IDLE, counter=0, all ce_n/oe_n/we_n=1, be_n=1111, addr=0, data buses high-Z, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, round-robin pointer=NREQ-1.
- REQ-015 Reset asserted mid-access abandons the access: strobes rise in the next cycle and no rsp_valid is issued.

Configuration
- REQ-016 Macro SRAM_ARB_RR_EN defined: round-robin arbitration; the search starts at (last granted port + 1) mod NREQ; the pointer updates on each grant.
- REQ-017 Macro SRAM_ARB_RR_EN undefined: fixed priority; the highest-index valid port wins; no pointer register exists.

Verification
- V1 Port 0 reads 0x8000_0010 with WAIT_CYCLES=1, base word 4 preloaded 0x1234_5678 -> req_ready[0] at T; base_ram_addr=0x00004, oe_n=0 for 2 cycles; rsp_valid[0] at T+3 with rsp_rdata=0x1234_5678.
- V2 Port 1 writes 0x8040_0008, we=0011, wdata=0xAABB_CCDD -> ext_ram_be_n=1100, we_n low for 1 cycle, ext word 2 bytes [15:0]=0xCCDD, rsp_valid[1] with rsp_rdata=0.
- V3 Both ports request continuously -> fixed build grants port 1 every time; SRAM_ARB_RR_EN build grants alternately 0,1,0,1, starting with port 0 after reset.
- V4 Read of 0x9000_0000 -> no ce_n asserted, rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0.
- V5 Reset asserted during the first ACCESS cycle of a write -> strobes high next cycle, no rsp_valid, bus high-Z, next request served normally.
